led_scan: RTL and testbench

- Row-scan engine directly downstream of the 8x8 LED frame store.
- Walks the store row by row with one-hot row/column addresses and captures the 8 pixel words of a row.
- Drives that row and its red/green column lines for a fixed dwell, then blanks before the next row.
- Exposes row index and frame-start timing for the light-pen position logic.

---
 rtl/led_scan.sv | 119 +++++++++++
 tb/tb_led_scan.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan.sv
// Row-scan engine for the 8x8 LED frame store: fetches one row of pixel words,
// shows it on the row/column drivers for a fixed dwell, blanks, then moves on.
module led_scan #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ram_grant,
    output logic [7:0] addr_row,
    output logic [7:0] addr_col,
    output logic       ram_we,
    output logic       fetch_active,
    input  logic [3:0] led_data,
    output logic [7:0] row_out,
    output logic [7:0] col_r,
    output logic [7:0] col_g,
    output logic [2:0] row_idx,
    output logic       frame_start
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHOW, BLANK} state_t;

    state_t        state, state_nxt;
    logic [3:0]    issue_cnt;   // 0..8; 8 means all eight addresses issued
    logic [2:0]    cap_cnt;
    logic          grant_d;
    logic [CW-1:0] tmr;
    logic [2:0]    pix     [8]; // {stored, G, R} per column
    logic [2:0]    pix_nxt [8];
    logic          issue, capture, last_cap, show_done, blank_done;
    logic          unused_lsb;

    assign unused_lsb = led_data[0];

    assign issue      = (state == FETCH) && ram_grant && !issue_cnt[3];
    assign capture    = (state == FETCH) && grant_d;
    assign last_cap   = capture && (cap_cnt == 3'd7);
    assign show_done  = (state == SHOW)  && (tmr == CW'(DWELL_CYCLES - 1));
    assign blank_done = (state == BLANK) && (tmr == CW'(BLANK_CYCLES - 1));

    assign addr_row     = 8'h01 << row_idx;
    assign addr_col     = issue_cnt[3] ? 8'h80 : (8'h01 << issue_cnt[2:0]);
    assign ram_we       = 1'b0;
    assign fetch_active = (state == FETCH);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)         state_nxt = FETCH;
            FETCH:   if (last_cap)   state_nxt = SHOW;
            SHOW:    if (show_done)  state_nxt = BLANK;
            BLANK:   if (blank_done) state_nxt = en ? FETCH : IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Slot 7 lands on the same edge that enters SHOW, so drive from the merged view.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            pix_nxt[k] = (capture && (cap_cnt == 3'(k))) ? led_data[3:1] : pix[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx     <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            grant_d     <= 1'b0;
            tmr         <= '0;
            frame_start <= 1'b0;
            row_out     <= '0;
            col_r       <= '0;
            col_g       <= '0;
            for (int k = 0; k < 8; k++) pix[k] <= '0;
        end else begin
            grant_d     <= issue;
            frame_start <= 1'b0;
            for (int k = 0; k < 8; k++) pix[k] <= pix_nxt[k];

            if (state_nxt != FETCH) issue_cnt <= '0;
            else if (issue)         issue_cnt <= issue_cnt + 4'd1;

            if (state != FETCH) cap_cnt <= '0;
            else if (capture)   cap_cnt <= cap_cnt + 3'd1;

            if (state_nxt != state)                    tmr <= '0;
            else if (state == SHOW || state == BLANK)  tmr <= tmr + 1'b1;

            if ((state == IDLE && en) || (blank_done && en && row_idx == 3'd7))
                frame_start <= 1'b1;

            if (blank_done) row_idx <= en ? row_idx + 3'd1 : 3'd0;

            if (state == FETCH && state_nxt == SHOW) begin
                row_out <= 8'h01 << row_idx;
                for (int k = 0; k < 8; k++) begin
                    col_r[k] <= pix_nxt[k][2] & pix_nxt[k][0];
                    col_g[k] <= pix_nxt[k][2] & pix_nxt[k][1];
                end
            end else if (show_done) begin
                row_out <= '0;
                col_r   <= '0;
                col_g   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan: frame-store model with 1-cycle read latency, randomized
// grants and pixel contents, expected column drive computed from pixel rules.
module tb_led_scan;

    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic       clk, rst, en, ram_grant;
    logic [7:0] addr_row, addr_col, row_out, col_r, col_g;
    logic       ram_we, fetch_active, frame_start;
    logic [3:0] led_data;
    logic [2:0] row_idx;

    logic [3:0] mem [8][8];
    int checks, passed, cyc, first_fs;

    led_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .ram_grant(ram_grant),
        .addr_row(addr_row), .addr_col(addr_col), .ram_we(ram_we),
        .fetch_active(fetch_active), .led_data(led_data), .row_out(row_out),
        .col_r(col_r), .col_g(col_g), .row_idx(row_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic int dec(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) led_data <= mem[dec(addr_row)][dec(addr_col)];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // A pixel lights a colour only if it is stored and that colour bit is set.
    function automatic logic [7:0] exp_red(input int r);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = mem[r][k][3] && mem[r][k][1];
        return v;
    endfunction

    function automatic logic [7:0] exp_green(input int r);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = mem[r][k][3] && mem[r][k][2];
        return v;
    endfunction

    // Starts on the first FETCH cycle of row r; ends on the cycle after its blank.
    // mode 0: always grant, 1: random grant, 2: deny 3 cycles at column 3.
    task automatic run_row(input int r, input int mode, input bit drop_en,
                           output int fetch_len, output logic [7:0] obs_r,
                           output logic [7:0] obs_g);
        logic [7:0] er, eg, erow, ecol;
        logic [2:0] ridx;
        int issued, denied, n;
        bit g;
        er = exp_red(r); eg = exp_green(r); erow = 8'h01 << r; ridx = r[2:0];
        issued = 0; denied = 0; n = 0;
        obs_r = '0; obs_g = '0;
        checks++;
        if (frame_start !== (r == 0))
            $display("FAIL frame_start row %0d: got %b want %b", r, frame_start, r == 0);
        else passed++;
        checks++;
        if (row_idx !== ridx) $display("FAIL row_idx: got %0d want %0d", row_idx, ridx);
        else passed++;
        forever begin
            n++;
            checks++;
            if (fetch_active !== 1'b1 || n > 200) begin
                $display("FAIL fetch row %0d cycle %0d: fetch_active=%b", r, n, fetch_active);
                break;
            end else passed++;
            if (issued == 8) begin
                ram_grant = 1'($urandom_range(0, 1));
                step();
                break;
            end
            ecol = 8'h01 << issued;
            checks++;
            if (addr_row !== erow || addr_col !== ecol || {row_out, col_r, col_g} !== 24'h0)
                $display("FAIL fetch_addr row %0d: row=%h col=%h want %h %h drive=%h",
                         r, addr_row, addr_col, erow, ecol, {row_out, col_r, col_g});
            else passed++;
            case (mode)
                0:       g = 1'b1;
                1:       g = ($urandom_range(0, 2) != 0);
                default: g = !(issued == 3 && denied < 3);
            endcase
            ram_grant = g;
            if (g) issued++; else denied++;
            step();
        end
        fetch_len = n;
        for (int i = 0; i < DWELL; i++) begin
            if (drop_en) en = 1'b0;
            checks++;
            if (fetch_active !== 1'b0 || row_out !== erow || col_r !== er || col_g !== eg
                || frame_start !== 1'b0)
                $display("FAIL show row %0d: row=%h r=%h g=%h want %h %h %h fa=%b",
                         r, row_out, col_r, col_g, erow, er, eg, fetch_active);
            else passed++;
            obs_r = col_r; obs_g = col_g;
            ram_grant = 1'($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < BLANK; i++) begin
            checks++;
            if ({row_out, col_r, col_g} !== 24'h0 || fetch_active !== 1'b0)
                $display("FAIL blank row %0d: drive=%h fa=%b", r, {row_out, col_r, col_g},
                         fetch_active);
            else passed++;
            step();
        end
        ram_grant = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ram_grant = 1'b0;
        repeat (3) step();
        checks++;
        if (addr_row !== 8'h01 || addr_col !== 8'h01 || {row_out, col_r, col_g} !== 24'h0
            || fetch_active !== 1'b0 || frame_start !== 1'b0 || row_idx !== 3'd0
            || ram_we !== 1'b0)
            $display("FAIL reset_state: ar=%h ac=%h drive=%h fa=%b fs=%b ri=%0d we=%b",
                     addr_row, addr_col, {row_out, col_r, col_g}, fetch_active,
                     frame_start, row_idx, ram_we);
        else passed++;
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (fetch_active !== 1'b0 || row_out !== 8'h00)
            $display("FAIL idle_hold: fa=%b row=%h want 0 0", fetch_active, row_out);
        else passed++;
    endtask

    task automatic test_frame();
        int len;
        logic [7:0] orr, og;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mem[r][c] = 4'h0;
        mem[2][5] = 4'b1100;
        mem[3][0] = 4'b0110;
        mem[3][7] = 4'b1110;
        en = 1'b1;
        step();
        first_fs = cyc;
        for (int r = 0; r < 8; r++) begin
            run_row(r, 0, 1'b0, len, orr, og);
            checks++;
            if (len !== 9) $display("FAIL fetch_len row %0d: got %0d want 9", r, len);
            else passed++;
            if (r == 2) begin
                checks++;
                if (og !== 8'h20 || orr !== 8'h00)
                    $display("FAIL row2_green: r=%h g=%h want 00 20", orr, og);
                else passed++;
            end
            if (r == 3) begin
                checks++;
                if (og !== 8'h80 || orr !== 8'h80)
                    $display("FAIL row3_yellow: r=%h g=%h want 80 80", orr, og);
                else passed++;
            end
        end
        checks++;
        if (frame_start !== 1'b1 || cyc - first_fs !== 8 * (9 + DWELL + BLANK))
            $display("FAIL frame_period: fs=%b period=%0d want 1 %0d", frame_start,
                     cyc - first_fs, 8 * (9 + DWELL + BLANK));
        else passed++;
    endtask

    task automatic test_contention();
        int len;
        logic [7:0] orr, og;
        run_row(0, 0, 1'b0, len, orr, og);
        run_row(1, 0, 1'b0, len, orr, og);
        run_row(2, 2, 1'b0, len, orr, og);
        checks++;
        if (len !== 12 || og !== 8'h20 || orr !== 8'h00)
            $display("FAIL contended_fetch: len=%0d r=%h g=%h want 12 00 20", len, orr, og);
        else passed++;
        run_row(3, 1, 1'b0, len, orr, og);
        checks++;
        if (og !== 8'h80 || orr !== 8'h80)
            $display("FAIL random_grant_row3: r=%h g=%h want 80 80", orr, og);
        else passed++;
    endtask

    task automatic test_en_drop();
        int len;
        logic [7:0] orr, og;
        run_row(4, 1, 1'b1, len, orr, og);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetch_active !== 1'b0 || {row_out, col_r, col_g} !== 24'h0
                || row_idx !== 3'd0 || addr_row !== 8'h01 || frame_start !== 1'b0)
                $display("FAIL en_drop_idle: fa=%b drive=%h ri=%0d ar=%h", fetch_active,
                         {row_out, col_r, col_g}, row_idx, addr_row);
            else passed++;
            step();
        end
    endtask

    task automatic test_random();
        int len;
        logic [7:0] orr, og;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mem[r][c] = 4'($urandom_range(0, 15));
        en = 1'b1;
        step();
        for (int r = 0; r < 8; r++) run_row(r, 1, 1'b0, len, orr, og);
        checks++;
        if (fetch_active !== 1'b1 || frame_start !== 1'b1 || row_idx !== 3'd0)
            $display("FAIL wrap: fa=%b fs=%b ri=%0d want 1 1 0", fetch_active, frame_start,
                     row_idx);
        else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        int len;
        logic [7:0] orr, og;
        ram_grant = 1'b1;
        repeat (3) step();
        rst = 1'b1; en = 1'b0;
        step();
        checks++;
        if (fetch_active !== 1'b0 || addr_row !== 8'h01 || addr_col !== 8'h01
            || {row_out, col_r, col_g} !== 24'h0 || row_idx !== 3'd0 || frame_start !== 1'b0)
            $display("FAIL reset_mid_fetch: fa=%b ar=%h ac=%h drive=%h ri=%0d", fetch_active,
                     addr_row, addr_col, {row_out, col_r, col_g}, row_idx);
        else passed++;
        rst = 1'b0; ram_grant = 1'b0;
        step();
        checks++;
        if (fetch_active !== 1'b0 || row_out !== 8'h00)
            $display("FAIL post_reset_idle: fa=%b row=%h", fetch_active, row_out);
        else passed++;
        en = 1'b1;
        step();
        run_row(0, 1, 1'b1, len, orr, og);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; ram_grant = 1'b0;
        checks = 0; passed = 0; cyc = 0; first_fs = 0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mem[r][c] = 4'h0;
        test_reset();
        test_frame();
        test_contention();
        test_en_drop();
        test_random();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
